// File: rtl/dino_pkg.sv
// Shared Dino Run encodings: obstacle types, spawner states, LFSR constants.
// Pure definitions; no latency or flow control of its own.
package dino_pkg;

    typedef enum logic [1:0] {
        OBS_SMALL = 2'd0,
        OBS_LARGE = 2'd1,
        OBS_BIRD  = 2'd2
    } obs_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNT,
        ST_OFFER,
        ST_HALT
    } spawner_state_t;

    localparam logic [7:0] LFSR_LOCKUP = 8'hFF;
    localparam logic [1:0] MAX_LEVEL   = 2'd3;

    // Top two LFSR bits pick the obstacle; small cactus is twice as likely.
    function automatic obs_type_t decode_type(input logic [1:0] sel, input logic bird_en);
        case (sel)
            2'b10:   return OBS_LARGE;
            2'b11:   return bird_en ? OBS_BIRD : OBS_LARGE;
            default: return OBS_SMALL;
        endcase
    endfunction

endpackage

// File: rtl/spawn_gap_timer.sv
// Loadable frame-gap down-counter; expire pulses combinationally on the tick that hits 1.
// Latency: load takes effect next cycle; no backpressure (caller gates tick).
module spawn_gap_timer #(
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    localparam logic [GAP_W-1:0] ONE = GAP_W'(1);

    logic [GAP_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign expire = tick && !load && (cnt == ONE);

endmodule

// File: rtl/obstacle_spawner.sv
// Turns LFSR values into obstacle spawn offers after a random frame gap; tracks difficulty.
// Latency: offer one cycle after the gap-th tick; backpressure holds the offer and stalls the gap timer.
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int MIN_GAP      = 24,
    parameter int GAP_W        = 8,
    parameter int LEVEL_SPAWNS = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             game_run,
    input  logic             tick,
    input  logic             collision,
    input  logic             bird_en,
    input  logic [7:0]       rnd,
    output logic             lfsr_en,
    output logic             spawn_valid,
    input  logic             spawn_ready,
    output logic [1:0]       spawn_type,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] spawn_count,
    output logic             halted
);

    localparam int               STEP_W    = $clog2(LEVEL_SPAWNS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LEVEL_SPAWNS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    spawner_state_t    state;
    logic [STEP_W-1:0] step_cnt;
    logic [7:0]        r_eff;
    logic [5:0]        rnd_gap;
    logic [GAP_W-1:0]  gap_load;
    logic              gap_expire;

    // An XNOR LFSR stuck at all-ones would otherwise pin the gap and type forever.
    assign r_eff    = (rnd == LFSR_LOCKUP) ? 8'h00 : rnd;
    assign rnd_gap  = r_eff[5:0] >> level;
    assign gap_load = GAP_W'(MIN_GAP) + GAP_W'(rnd_gap);
    assign lfsr_en  = (state == ST_LOAD);

    spawn_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_LOAD),
        .load_val (gap_load),
        .tick     (tick && state == ST_COUNT),
        .expire   (gap_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            spawn_valid <= 1'b0;
            spawn_type  <= OBS_SMALL;
            level       <= '0;
            spawn_count <= '0;
            halted      <= 1'b0;
            step_cnt    <= '0;
        end else if (state == ST_IDLE) begin
            spawn_valid <= 1'b0;
            halted      <= 1'b0;
            if (game_run) begin
                state       <= ST_LOAD;
                level       <= '0;
                spawn_count <= '0;
                step_cnt    <= '0;
            end
        end else if (!game_run) begin
            state       <= ST_IDLE;
            spawn_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (collision) begin
            // Collision outranks a same-cycle handshake, so a frozen game never counts it.
            state       <= ST_HALT;
            spawn_valid <= 1'b0;
            halted      <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    spawn_type <= decode_type(r_eff[7:6], bird_en);
                    state      <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (gap_expire) begin
                        state       <= ST_OFFER;
                        spawn_valid <= 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (spawn_ready) begin
                        state       <= ST_LOAD;
                        spawn_valid <= 1'b0;
                        if (spawn_count != '1) begin
                            spawn_count <= spawn_count + CNT_ONE;
                        end
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            if (level != MAX_LEVEL) begin
                                level <= level + 2'd1;
                            end
                        end else begin
                            step_cnt <= step_cnt + STEP_ONE;
                        end
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: directed scenarios plus randomized play,
// all compared each cycle against a frame-level behavioural model.
module tb_obstacle_spawner;

    localparam int MIN_GAP      = 24;
    localparam int LEVEL_SPAWNS = 8;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             game_run;
    logic             tick;
    logic             collision;
    logic             bird_en;
    logic [7:0]       rnd;
    logic             lfsr_en;
    logic             spawn_valid;
    logic             spawn_ready;
    logic [1:0]       spawn_type;
    logic [1:0]       level;
    logic [CNT_W-1:0] spawn_count;
    logic             halted;

    obstacle_spawner #(
        .MIN_GAP      (MIN_GAP),
        .GAP_W        (8),
        .LEVEL_SPAWNS (LEVEL_SPAWNS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .game_run    (game_run),
        .tick        (tick),
        .collision   (collision),
        .bird_en     (bird_en),
        .rnd         (rnd),
        .lfsr_en     (lfsr_en),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_type  (spawn_type),
        .level       (level),
        .spawn_count (spawn_count),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a game in progress, waiting on a load, a number of
    // frames left, or an offer outstanding; level derived from total accepts.
    bit m_active  = 1'b0;
    bit m_halt    = 1'b0;
    bit m_loading = 1'b0;
    bit m_offer   = 1'b0;
    int m_left    = 0;
    int m_acc     = 0;
    int m_type    = 0;
    int m_r       = 0;

    function automatic int m_level();
        int l;
        l = m_acc / LEVEL_SPAWNS;
        return (l > 3) ? 3 : l;
    endfunction

    function automatic int m_count();
        return (m_acc > 65535) ? 65535 : m_acc;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0; m_halt = 1'b0; m_loading = 1'b0; m_offer = 1'b0;
            m_left = 0; m_acc = 0;
        end else if (!m_active) begin
            if (game_run) begin
                m_active = 1'b1; m_loading = 1'b1; m_acc = 0; m_halt = 1'b0; m_offer = 1'b0;
            end
        end else if (!game_run) begin
            m_active = 1'b0; m_halt = 1'b0; m_loading = 1'b0; m_offer = 1'b0;
        end else if (collision) begin
            m_halt = 1'b1; m_loading = 1'b0; m_offer = 1'b0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_loading) begin
            m_r    = (rnd == 8'hFF) ? 0 : int'(rnd);
            m_left = MIN_GAP + ((m_r % 64) >> m_level());
            m_type = (m_r / 64 < 2) ? 0 : (m_r / 64 == 2) ? 1 : (bird_en ? 2 : 1);
            m_loading = 1'b0;
        end else if (m_offer) begin
            if (spawn_ready) begin
                m_acc++; m_offer = 1'b0; m_loading = 1'b1;
            end
        end else if (tick) begin
            m_left--;
            if (m_left == 0) m_offer = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("lfsr_en", lfsr_en, m_loading);
        chk("spawn_valid", spawn_valid, m_offer);
        chk("halted", halted, m_halt);
        chk("level", level, m_level());
        chk("spawn_count", spawn_count, m_count());
        if (m_offer) chk("spawn_type", spawn_type, m_type);
    end

    task automatic tick_until_valid(output int n);
        n = 0;
        while (!spawn_valid && n < 300) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            n++;
            @(negedge clk);
        end
        chk("offer_reached", spawn_valid, 1);
    endtask

    // Called at a negedge while in LOAD; returns ticks needed to reach the offer.
    task automatic run_spawn(output int n);
        @(negedge clk);
        tick_until_valid(n);
    endtask

    task automatic accept(input logic [7:0] nr, input logic nb);
        spawn_ready = 1'b1;
        rnd         = nr;
        bird_en     = nb;
        @(negedge clk);
        spawn_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    int n;
    int st;
    int cnt;

    initial begin
        reset = 1'b0; game_run = 1'b0; tick = 1'b0; collision = 1'b0;
        bird_en = 1'b0; spawn_ready = 1'b0; rnd = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_lfsr_en", lfsr_en, 0);
        chk("rst_valid", spawn_valid, 0);
        chk("rst_type", spawn_type, 0);
        chk("rst_level", level, 0);
        chk("rst_count", spawn_count, 0);
        chk("rst_halted", halted, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        rnd = 8'h05; game_run = 1'b1;
        @(negedge clk);
        chk("start_lfsr_en", lfsr_en, 1);
        run_spawn(n);
        chk("gap_05", n, 29);
        chk("type_05", spawn_type, 0);

        st  = spawn_type;
        cnt = spawn_count;
        repeat (10) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
        end
        chk("stall_valid", spawn_valid, 1);
        chk("stall_type", spawn_type, st);
        chk("stall_count", spawn_count, cnt);

        accept(8'hC0, 1'b0);
        chk("acc_count", spawn_count, cnt + 1);
        chk("acc_valid", spawn_valid, 0);
        chk("acc_lfsr_en", lfsr_en, 1);
        run_spawn(n);
        chk("gap_C0", n, 24);
        chk("type_C0_nobird", spawn_type, 1);

        accept(8'hC0, 1'b1);
        run_spawn(n);
        chk("gap_C0_bird", n, 24);
        chk("type_C0_bird", spawn_type, 2);

        accept(8'hFF, 1'b0);
        run_spawn(n);
        chk("gap_FF", n, 24);
        chk("type_FF", spawn_type, 0);

        for (int i = 0; i < 4; i++) begin
            accept(8'h00, 1'b0);
            run_spawn(n);
        end
        accept(8'h3F, 1'b0);
        chk("level_after_8", level, 1);
        run_spawn(n);
        chk("gap_3F_level1", n, 55);

        for (int i = 0; i < 16; i++) begin
            accept(8'h40, 1'b0);
            run_spawn(n);
        end
        chk("level_after_24", level, 3);
        chk("count_after_24", spawn_count, 24);
        for (int i = 0; i < 2; i++) begin
            accept(8'h00, 1'b0);
            run_spawn(n);
        end
        chk("level_sat", level, 3);

        cnt = spawn_count;
        collision = 1'b1; spawn_ready = 1'b1;
        @(negedge clk);
        collision = 1'b0; spawn_ready = 1'b0;
        chk("coll_halted", halted, 1);
        chk("coll_valid", spawn_valid, 0);
        chk("coll_count", spawn_count, cnt);
        repeat (3) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
        end
        chk("halt_hold", halted, 1);
        game_run = 1'b0;
        @(negedge clk);
        chk("idle_halted", halted, 0);
        chk("idle_count_kept", spawn_count, cnt);
        game_run = 1'b1; rnd = 8'($urandom_range(255));
        @(negedge clk);
        chk("newgame_level", level, 0);
        chk("newgame_count", spawn_count, 0);
        chk("newgame_lfsr_en", lfsr_en, 1);

        for (int i = 0; i < 3000; i++) begin
            game_run    = ($urandom_range(199) != 0);
            collision   = ($urandom_range(299) == 0);
            tick        = ($urandom_range(2) == 0);
            spawn_ready = 1'($urandom_range(1));
            bird_en     = 1'($urandom_range(1));
            rnd         = 8'($urandom_range(255));
            @(negedge clk);
        end

        game_run = 1'b0; collision = 1'b0; tick = 1'b0; spawn_ready = 1'b0; rnd = 8'h00;
        @(negedge clk);
        game_run = 1'b1;
        @(negedge clk);
        run_spawn(n);
        accept(8'h00, 1'b0);
        @(negedge clk);
        repeat (3) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
        end
        chk("pre_reset_count", spawn_count, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_lfsr_en", lfsr_en, 0);
        chk("arst_valid", spawn_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_count", spawn_count, 0);
        chk("arst_halted", halted, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_lfsr_en", lfsr_en, 1);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
Consumes the 8-bit pseudo-random value from the game's LFSR and turns it into obstacle spawn events for the Dino Run playfield. It picks a random frame gap and obstacle type, counts frame ticks, then offers a spawn to the obstacle renderer over a valid/ready handshake. It advances the LFSR through its enable input, tracks the difficulty level, and freezes on collision.

Parameters:
MIN_GAP, 24, minimum frames between spawns; must be >= 1.
GAP_W, 8, gap counter width; MIN_GAP + 63 must be < 2^GAP_W.
LEVEL_SPAWNS, 8, accepted spawns per difficulty level step.
CNT_W, 16, width of the accepted-spawn counter.

Ports:
clk  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-low reset.
game_run  in  1  high while a game is in progress.
tick  in  1  one-cycle pulse once per video frame.
collision  in  1  dino/obstacle collision; level-sensitive.
bird_en  in  1  allows bird obstacles.
rnd  in  8  current LFSR output.
lfsr_en  out  1  one-cycle pulse that advances the LFSR.
spawn_valid  out  1  spawn offer pending.
spawn_ready  in  1  renderer accepts the offer.
spawn_type  out  2  0 = small cactus, 1 = large cactus, 2 = bird; 3 is never driven.
level  out  2  difficulty level, saturates at 3.
spawn_count  out  CNT_W  number of accepted spawns, saturating.
halted  out  1  high in HALT state.

Behaviour:
- Reset (reset = 0, async): state IDLE; lfsr_en 0, spawn_valid 0, spawn_type 0, level 0, spawn_count 0, halted 0; gap counter 0. Reset mid-operation drops any pending offer immediately.
- States: IDLE, LOAD, COUNT, OFFER, HALT.
- Priority in every non-IDLE state: game_run = 0 beats collision = 1, which beats all other transitions.
  - game_run low -> IDLE.
  - Else collision high -> HALT.
- IDLE: outputs idle. On game_run = 1 -> LOAD, and clear level and spawn_count the same cycle (new game).
- LOAD (exactly one cycle):
  - Sample rnd as r; if r == 8'hFF (XNOR lockup value), use 8'h00 instead.
  - Gap load value = MIN_GAP + (r[5:0] >> level), which is always >= MIN_GAP.
  - Type from r[7:6]: 00 or 01 -> 0; 10 -> 1; 11 -> 2 if bird_en, else 1. Register the type into spawn_type.
  - lfsr_en = 1 during this cycle only.
  - A tick arriving in LOAD is ignored.
  - Next state COUNT.
- COUNT:
  - Each tick decrements the gap counter.
  - A tick seen while the counter == 1 -> OFFER next cycle.
  - Exactly "gap" ticks separate LOAD from OFFER.
- OFFER:
  - spawn_valid = 1; spawn_type stays stable until accepted.
  - Ticks are ignored (backpressure stalls the game-side timer; no tick is counted).
  - On spawn_ready = 1 (transfer):
    - spawn_count increments, saturating at all ones.
    - A level-step counter increments; when it reaches LEVEL_SPAWNS it wraps to 0 and level increments, saturating at 3.
    - Next state LOAD, so spawn_valid drops the next cycle.
  - Collision and spawn_ready in the same cycle: HALT wins; no transfer, counts unchanged.
- HALT: spawn_valid 0, halted 1; ticks ignored; remains until game_run = 0 -> IDLE. level and spawn_count stay readable for the score display.
- spawn_valid, spawn_type, level, spawn_count and halted are all registered outputs (no combinational path from inputs). lfsr_en is decoded from state only.

Decomposition:
- Shared package dino_pkg holds:
  - obstacle type encodings (OBS_SMALL = 0, OBS_LARGE = 1, OBS_BIRD = 2);
  - spawner state encoding;
  - LFSR lockup constant 8'hFF;
  - MAX_LEVEL = 3.
- One natural sub-module, spawn_gap_timer: loadable down-counter with inputs load, load_val and tick, and a single-cycle "expire" output. The FSM, type decode and level/count logic stay in obstacle_spawner.

Test Plan:
- Reset low, then game_run = 1 with rnd = 8'h05 and level 0 -> one lfsr_en pulse 1 cycle after game_run rises; spawn_valid rises after exactly 29 ticks with spawn_type = 0.
- rnd = 8'hC0: with bird_en = 0 -> spawn_type = 1; with bird_en = 1 -> spawn_type = 2. rnd = 8'hFF -> treated as 8'h00: type 0, gap 24.
- Hold spawn_ready = 0 for 10 ticks in OFFER -> spawn_valid and spawn_type stay stable and spawn_count unchanged. Then spawn_ready = 1 for 1 cycle -> spawn_count +1, spawn_valid drops, and the next lfsr_en pulse follows.
- Accept 8 spawns -> level = 1. Next LOAD with rnd = 8'h3F gives a gap of 55 ticks. After 24 accepted spawns, level stays at 3 from then on.
- In OFFER, raise collision and spawn_ready together -> HALT, halted = 1, spawn_valid = 0, spawn_count unchanged. Drop game_run -> IDLE. Raise game_run again -> level and spawn_count clear.
- Assert reset mid-COUNT between clock edges -> all outputs zero immediately, without waiting for a clock edge. Release reset with game_run = 1 -> a fresh LOAD.
